// File: rtl/primary_ray_emitter_pkg.sv
// Shared fixed-point ray types, emitter state encoding and vector helpers
// for the primary ray emitter and its adder.
package primary_ray_emitter_pkg;

  localparam int unsigned FIX_W    = 32;
  localparam int unsigned FIX_FRAC = 16;

  typedef logic signed [FIX_W-1:0] fixed;

  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } point;

  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } vector;

  typedef struct packed {
    point  start;
    vector dir;
  } ray;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } emitter_state_t;

  // Componentwise a - b, wrapping in FIX_W bits.
  function automatic vector vec_sub(input point a, input point b);
    vector v;
    v.x = a.x - b.x;
    v.y = a.y - b.y;
    v.z = a.z - b.z;
    return v;
  endfunction

endpackage

// File: rtl/primary_ray_emitter_vector_add.sv
// Combinational three-component fixed-point adder, wrap-around on overflow.
module vector_add
  import primary_ray_emitter_pkg::*;
(
  input  vector a,
  input  vector b,
  output vector sum
);

  always_comb begin
    sum.x = a.x + b.x;
    sum.y = a.y + b.y;
    sum.z = a.z + b.z;
  end

endmodule

// File: rtl/primary_ray_emitter.sv
// Emits one primary ray per pixel in raster order using an incremental
// add-only walk across the image plane; valid/ready handshake on the output.
module primary_ray_emitter
  import primary_ray_emitter_pkg::*;
#(
  parameter int H_RES = 64,
  parameter int V_RES = 48,
  parameter int PXW   = $clog2((H_RES > V_RES) ? H_RES : V_RES) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  point           origin,
  input  point           corner,
  input  vector          du,
  input  vector          dv,
  output logic           ray_valid,
  input  logic           ray_ready,
  output ray             r,
  output logic [PXW-1:0] px_x,
  output logic [PXW-1:0] px_y,
  output logic           last,
  output logic           busy,
  output logic           done
);

  localparam logic [PXW-1:0] X_END = PXW'(H_RES - 1);
  localparam logic [PXW-1:0] Y_END = PXW'(V_RES - 1);
  localparam logic [PXW-1:0] PX_ONE = PXW'(1);

  emitter_state_t state_q, state_d;
  point           origin_q, origin_d;
  vector          du_q, du_d;
  vector          dv_q, dv_d;
  vector          cur_q, cur_d;
  vector          row_base_q, row_base_d;
  logic           ray_valid_q, ray_valid_d;
  logic [PXW-1:0] px_x_q, px_x_d;
  logic [PXW-1:0] px_y_q, px_y_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  vector          col_next;
  vector          row_next;
  logic [PXW-1:0] nx;
  logic [PXW-1:0] ny;
  logic           xfer;

  vector_add u_col_add (
    .a   (cur_q),
    .b   (du_q),
    .sum (col_next)
  );

  vector_add u_row_add (
    .a   (row_base_q),
    .b   (dv_q),
    .sum (row_next)
  );

  always_comb begin
    state_d     = state_q;
    origin_d    = origin_q;
    du_d        = du_q;
    dv_d        = dv_q;
    cur_d       = cur_q;
    row_base_d  = row_base_q;
    ray_valid_d = ray_valid_q;
    px_x_d      = px_x_q;
    px_y_d      = px_y_q;
    last_d      = last_q;
    done_d      = 1'b0;
    xfer        = ray_valid_q & ray_ready;
    nx          = px_x_q + PX_ONE;
    ny          = px_y_q + PX_ONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          origin_d   = origin;
          du_d       = du;
          dv_d       = dv;
          cur_d      = vec_sub(corner, origin);
          row_base_d = vec_sub(corner, origin);
        end
      end
      LOAD: begin
        state_d     = EMIT;
        ray_valid_d = 1'b1;
        px_x_d      = '0;
        px_y_d      = '0;
        last_d      = (X_END == '0) && (Y_END == '0);
      end
      EMIT: begin
        if (xfer) begin
          if (last_q) begin
            state_d     = DONE;
            ray_valid_d = 1'b0;
            last_d      = 1'b0;
            done_d      = 1'b1;
          end else if (px_x_q == X_END) begin
            // cur restarts from the advanced row base, not from cur itself
            row_base_d = row_next;
            cur_d      = row_next;
            px_x_d     = '0;
            px_y_d     = ny;
            last_d     = (X_END == '0) && (ny == Y_END);
          end else begin
            cur_d  = col_next;
            px_x_d = nx;
            last_d = (nx == X_END) && (px_y_q == Y_END);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      ray_valid_d = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      origin_q    <= '0;
      du_q        <= '0;
      dv_q        <= '0;
      cur_q       <= '0;
      row_base_q  <= '0;
      ray_valid_q <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      du_q        <= du_d;
      dv_q        <= dv_d;
      cur_q       <= cur_d;
      row_base_q  <= row_base_d;
      ray_valid_q <= ray_valid_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ray_valid = ray_valid_q;
  assign r         = {origin_q, cur_q};
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
